// File: rtl/xor_fold_serial_3_35.sv
// Serial XOR fold: accepts NUM_VEC operand words over a valid/ready stream and
// presents their bitwise XOR, with a frame error flag, on a valid/ready output.
module xor_fold_serial_3_35 #(
  parameter int NUM_VEC = 3,
  parameter int WIDTH   = 35
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_xor,
  output logic             frame_err
);

  localparam int CW = (NUM_VEC > 2) ? $clog2(NUM_VEC) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(NUM_VEC - 1);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic              err_q, err_d;
  logic              closing;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACCUM;
      cnt_q   <= '0;
      acc_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
    end
  end

  // The closing beat is the first of: count reaching the frame size, or in_last.
  assign closing = (cnt_q == LAST_BEAT) || in_last;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    err_d   = err_q;
    case (state_q)
      ACCUM: begin
        if (in_valid) begin
          acc_d = (cnt_q == '0) ? in_data : (acc_q ^ in_data);
          if (closing) begin
            state_d = HOLD;
            cnt_d   = '0;
            err_d   = (in_last && (cnt_q != LAST_BEAT)) ||
                      (!in_last && (cnt_q == LAST_BEAT));
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = ACCUM;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = ACCUM;
        cnt_d   = '0;
      end
    endcase
  end

  // in_ready depends only on state, so nothing combinational reaches it.
  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign out_xor   = acc_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_xor_fold_serial_3_35.sv
// Directed and randomized frames for xor_fold_serial_3_35, checked against a
// frame-level XOR model held in the bench.
module tb_xor_fold_serial_3_35;
  localparam int NV = 3;
  localparam int W  = 35;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_xor;
  logic         frame_err;

  int vectors = 0;
  int miscompares = 0;

  logic [W-1:0] fr_data[$];
  logic         fr_last[$];

  xor_fold_serial_3_35 #(.NUM_VEC(NV), .WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_xor(out_xor), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one beat, optionally after idle cycles; returns at transfer edge + 1.
  task automatic send_beat(input logic [W-1:0] d, input logic l, input int gap);
    int n;
    n = 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", W'(in_ready), W'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
  endtask

  // Expected result after the closing beat, with stall cycles of backpressure.
  task automatic get_result(input logic [W-1:0] exp, input logic exp_err, input int stall);
    out_ready = (stall == 0);
    chk("out_valid_rise", W'(out_valid), W'(1));
    chk("out_xor", out_xor, exp);
    chk("frame_err", W'(frame_err), W'(exp_err));
    chk("in_ready_hold", W'(in_ready), W'(0));
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      chk("stall_valid", W'(out_valid), W'(1));
      chk("stall_xor", out_xor, exp);
      chk("stall_err", W'(frame_err), W'(exp_err));
      chk("stall_in_ready", W'(in_ready), W'(0));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("out_valid_drop", W'(out_valid), W'(0));
    chk("in_ready_back", W'(in_ready), W'(1));
  endtask

  // Model: a frame's result is the XOR of its beats; the error flag reflects a
  // short frame ended by last, or a full frame whose final beat lacked last.
  task automatic run_frame(input int stall, input int gap);
    logic [W-1:0] exp;
    logic         lastf;
    int           len;
    exp = '0;
    len = fr_data.size();
    for (int i = 0; i < len; i++) begin
      send_beat(fr_data[i], fr_last[i], (i == 0) ? 0 : gap);
      exp = exp ^ fr_data[i];
    end
    lastf = fr_last[len-1];
    get_result(exp, (lastf && len < NV) || (!lastf && len == NV), stall);
    fr_data.delete();
    fr_last.delete();
  endtask

  task automatic push(input logic [W-1:0] d, input logic l);
    fr_data.push_back(d);
    fr_last.push_back(l);
  endtask

  initial begin
    int len;
    logic [W-1:0] d;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_out_xor", out_xor, '0);
    chk("rst_frame_err", W'(frame_err), W'(0));
    chk("rst_in_ready", W'(in_ready), W'(1));
    rst = 1'b0;

    // Nominal frame, out_ready already high.
    out_ready = 1'b1;
    push(35'd9548617438, 1'b0); push(35'd14066143831, 1'b0); push(35'd7041284509, 1'b1);
    run_frame(0, 0);
    chk("nominal_literal", out_xor, 35'd3707600148);

    // Backpressure for 5 cycles.
    push(35'd9548617438, 1'b0); push(35'd14066143831, 1'b0); push(35'd7041284509, 1'b1);
    run_frame(5, 0);

    // Gaps inside a frame, then all-ones/zero/all-ones back to back.
    push(35'd9548617438, 1'b0); push(35'd14066143831, 1'b0); push(35'd7041284509, 1'b1);
    run_frame(0, 3);
    push(35'h7_FFFF_FFFF, 1'b0); push(35'h0, 1'b0); push(35'h7_FFFF_FFFF, 1'b1);
    run_frame(0, 0);

    // Early last, then a clean frame clears the error.
    push(35'h1, 1'b0); push(35'h2, 1'b1);
    run_frame(0, 0);
    push(35'd9548617438, 1'b0); push(35'd14066143831, 1'b0); push(35'd7041284509, 1'b1);
    run_frame(0, 0);

    // Missing last.
    push(35'h5, 1'b0); push(35'h3, 1'b0); push(35'h1, 1'b0);
    run_frame(2, 0);

    // Reset mid-frame discards the partial frame.
    send_beat(35'h1234, 1'b0, 0);
    send_beat(35'h5678, 1'b0, 0);
    rst = 1'b1;
    #2;
    chk("midrst_out_valid", W'(out_valid), W'(0));
    chk("midrst_acc", out_xor, '0);
    chk("midrst_err", W'(frame_err), W'(0));
    chk("midrst_in_ready", W'(in_ready), W'(1));
    @(posedge clk);
    #1;
    rst = 1'b0;
    push(35'd9548617438, 1'b0); push(35'd14066143831, 1'b0); push(35'd7041284509, 1'b1);
    run_frame(0, 0);

    // Randomized frames: random length, last placement, gaps and stalls.
    for (int f = 0; f < 40; f++) begin
      len = $urandom_range(1, NV);
      for (int i = 0; i < len; i++) begin
        d = W'({$urandom, $urandom});
        if (i < len - 1) push(d, 1'b0);
        else if (len < NV) push(d, 1'b1);
        else push(d, 1'($urandom_range(0, 1)));
      end
      run_frame($urandom_range(0, 3), $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
